// File: rtl/rpn_pkg.sv
// Shared opcode, error-code and state definitions for the RPN evaluator.
// RPN_EVALUATOR_MUL_EN makes opcode 7 a binary multiply instead of an illegal opcode.
package rpn_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_PEEK = 3'd5;
    localparam logic [2:0] OP_DROP = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP1,
        S_POP2,
        S_CALC,
        S_TOP,
        S_TOPW
    } state_e;

    // Opcodes that pop two entries and push one result.
    function automatic logic is_binary(input logic [2:0] op);
        logic bin;
        bin = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
              (op == OP_OR)  || (op == OP_XOR);
`ifdef RPN_EVALUATOR_MUL_EN
        bin = bin || (op == OP_MUL);
`endif
        return bin;
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN evaluator: result = A op B, modulo 2^WIDTH.
// The multiplier exists only when RPN_EVALUATOR_MUL_EN is defined.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
`ifdef RPN_EVALUATOR_MUL_EN
            OP_MUL:  result_o = a_i * b_i;
`endif
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rpn_evaluator.sv
// RPN token evaluator driving an external stack through registered strobes.
// Define RPN_EVALUATOR_MUL_EN to enable opcode 7 as MUL.
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDRESS_BITS = 10
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    TokValid,
    output logic                    TokReady,
    input  logic                    TokIsOp,
    input  logic [WIDTH-1:0]        TokData,
    output logic [WIDTH-1:0]        Result,
    output logic                    ResultValid,
    output logic                    ErrValid,
    output logic [1:0]              ErrCode,
    output logic                    StkEnable,
    output logic                    StkPush,
    output logic                    StkPop,
    output logic                    StkTop,
    output logic [WIDTH-1:0]        StkDataIn,
    input  logic [WIDTH-1:0]        StkDataOut,
    input  logic                    StkFull,
    input  logic                    StkEmpty,
    input  logic [ADDRESS_BITS-1:0] StkPtr
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             err_valid_q, err_valid_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [WIDTH-1:0] data_in_q, data_in_d;
    logic             push_q, pop_q, top_q, enable_q;
    logic             push_d, pop_d, top_d;
    logic [WIDTH-1:0] alu_y;
    logic [2:0]       tok_op;
    logic             has_one, has_two;

    assign tok_op  = TokData[2:0];
    assign has_one = !StkEmpty;
    assign has_two = !StkEmpty && (StkPtr != '0);

    // A arrives from the second pop during CALC; B was latched in POP2.
    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i      (StkDataOut),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_y)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        b_d            = b_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        err_valid_d    = 1'b0;
        err_code_d     = err_code_q;
        data_in_d      = data_in_q;

        case (state_q)
            S_IDLE: begin
                if (TokValid) begin
                    if (!TokIsOp) begin
                        if (StkFull) begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_OVERFLOW;
                        end else begin
                            data_in_d = TokData;
                            state_d   = S_PUSH;
                        end
                    end else begin
                        op_d = tok_op;
                        if (is_binary(tok_op)) begin
                            if (has_two) state_d = S_POP1;
                            else begin
                                err_valid_d = 1'b1;
                                err_code_d  = ERR_UNDERFLOW;
                            end
                        end else if (tok_op == OP_PEEK || tok_op == OP_DROP) begin
                            if (has_one) state_d = (tok_op == OP_PEEK) ? S_TOP : S_POP1;
                            else begin
                                err_valid_d = 1'b1;
                                err_code_d  = ERR_UNDERFLOW;
                            end
                        end else begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_ILLEGAL;
                        end
                    end
                end
            end
            S_PUSH: state_d = S_IDLE;
            S_POP1: state_d = (op_q == OP_DROP) ? S_IDLE : S_POP2;
            S_POP2: begin
                b_d     = StkDataOut;
                state_d = S_CALC;
            end
            S_CALC: begin
                result_d       = alu_y;
                result_valid_d = 1'b1;
                data_in_d      = alu_y;
                state_d        = S_PUSH;
            end
            S_TOP:  state_d = S_TOPW;
            S_TOPW: begin
                result_d       = StkDataOut;
                result_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each is high for exactly its state.
    assign push_d = (state_d == S_PUSH);
    assign pop_d  = (state_d == S_POP1) || (state_d == S_POP2);
    assign top_d  = (state_d == S_TOP);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            b_q            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_valid_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
            data_in_q      <= '0;
            push_q         <= 1'b0;
            pop_q          <= 1'b0;
            top_q          <= 1'b0;
            enable_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            b_q            <= b_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_valid_q    <= err_valid_d;
            err_code_q     <= err_code_d;
            data_in_q      <= data_in_d;
            push_q         <= push_d;
            pop_q          <= pop_d;
            top_q          <= top_d;
            enable_q       <= 1'b1;
        end
    end

    assign TokReady    = (state_q == S_IDLE);
    assign Result      = result_q;
    assign ResultValid = result_valid_q;
    assign ErrValid    = err_valid_q;
    assign ErrCode     = err_code_q;
    assign StkEnable   = enable_q;
    assign StkPush     = push_q;
    assign StkPop      = pop_q;
    assign StkTop      = top_q;
    assign StkDataIn   = data_in_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed self-checking bench for rpn_evaluator with a 16-entry behavioral stack.
// Expectations for opcode 7 follow RPN_EVALUATOR_MUL_EN.
module tb_rpn_evaluator;

    localparam int W  = 8;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          TokValid = 1'b0;
    logic          TokIsOp = 1'b0;
    logic [W-1:0]  TokData = '0;
    logic          TokReady;
    logic [W-1:0]  Result;
    logic          ResultValid, ErrValid;
    logic [1:0]    ErrCode;
    logic          StkEnable, StkPush, StkPop, StkTop;
    logic [W-1:0]  StkDataIn;
    logic [W-1:0]  StkDataOut;
    logic          StkFull, StkEmpty;
    logic [AB-1:0] StkPtr;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rpn_evaluator #(.WIDTH(W), .ADDRESS_BITS(AB)) dut (
        .Clk(clk), .Reset(rst), .TokValid(TokValid), .TokReady(TokReady),
        .TokIsOp(TokIsOp), .TokData(TokData), .Result(Result),
        .ResultValid(ResultValid), .ErrValid(ErrValid), .ErrCode(ErrCode),
        .StkEnable(StkEnable), .StkPush(StkPush), .StkPop(StkPop), .StkTop(StkTop),
        .StkDataIn(StkDataIn), .StkDataOut(StkDataOut), .StkFull(StkFull),
        .StkEmpty(StkEmpty), .StkPtr(StkPtr)
    );

    // Behavioral stack: ptr addresses the top entry, read data registered.
    logic [W-1:0] mem [16];
    logic [4:0]   cnt;
    logic [3:0]   tix;
    assign tix      = cnt[3:0] - 4'd1;
    assign StkFull  = (cnt == 5'd16);
    assign StkEmpty = (cnt == 5'd0);
    assign StkPtr   = StkEmpty ? 4'd0 : tix;

    always @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            StkDataOut <= '0;
        end else if (StkEnable) begin
            if (StkPush && !StkFull) begin
                mem[cnt[3:0]] <= StkDataIn;
                cnt <= cnt + 5'd1;
            end else if (StkPop && !StkEmpty) begin
                StkDataOut <= mem[tix];
                cnt <= cnt - 5'd1;
            end else if (StkTop && !StkEmpty) begin
                StkDataOut <= mem[tix];
            end
        end
    end

    int           res_cnt = 0, err_cnt = 0, stb_cnt = 0;
    logic [W-1:0] last_res = '0;
    logic [1:0]   last_err = '0;

    always @(negedge clk) begin
        if (ResultValid) begin
            res_cnt  <= res_cnt + 1;
            last_res <= Result;
        end
        if (ErrValid) begin
            err_cnt  <= err_cnt + 1;
            last_err <= ErrCode;
        end
        if (StkPush || StkPop || StkTop) stb_cnt <= stb_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic isop, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        while (!TokReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!TokReady) chk("send_ready_timeout", {31'd0, TokReady}, 32'd1);
        TokValid = 1'b1;
        TokIsOp  = isop;
        TokData  = d;
        @(negedge clk);
        TokValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!TokReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!TokReady) chk("idle_timeout", {31'd0, TokReady}, 32'd1);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        send(1'b0, d);
        wait_idle();
    endtask

    task automatic op_result(input logic [2:0] op, input logic [W-1:0] exp, input string tag);
        int r0;
        r0 = res_cnt;
        send(1'b1, {5'd0, op});
        wait_idle();
        chk(tag, {24'd0, last_res}, {24'd0, exp});
        chk("result_pulse_count", res_cnt - r0, 1);
    endtask

    task automatic op_error(input logic [2:0] op, input logic isop, input logic [1:0] code, input string tag);
        int e0, s0;
        e0 = err_cnt;
        s0 = stb_cnt;
        send(isop, {5'd0, op});
        wait_idle();
        chk(tag, {30'd0, last_err}, {30'd0, code});
        chk("err_pulse_count", err_cnt - e0, 1);
        chk("err_no_strobe", stb_cnt - s0, 0);
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_strobes", {28'd0, StkEnable, StkPush, StkPop, StkTop}, 32'd0);
        chk("rst_result", {22'd0, Result, ResultValid, ErrValid}, 32'd0);
        chk("rst_errcode", {30'd0, ErrCode}, 32'd0);
        chk("rst_datain", {24'd0, StkDataIn}, 32'd0);
        chk("rst_ready", {31'd0, TokReady}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("enable_after_rst", {31'd0, StkEnable}, 32'd1);

        // Push 5 with cycle-level timing, push 3, ADD timing, PEEK
        send(1'b0, 8'd5);
        chk("push_strobe", {31'd0, StkPush}, 32'd1);
        chk("push_data", {24'd0, StkDataIn}, 32'd5);
        chk("push_busy", {31'd0, TokReady}, 32'd0);
        @(negedge clk);
        chk("push_ready_back", {30'd0, TokReady, StkPush}, 32'd2);
        push(8'd3);
        send(1'b1, 8'd0);
        chk("add_pop1", {29'd0, StkPush, StkPop, StkTop}, 32'd2);
        @(negedge clk);
        chk("add_pop2", {29'd0, StkPush, StkPop, StkTop}, 32'd2);
        @(negedge clk);
        chk("add_calc_quiet", {29'd0, StkPush, StkPop, StkTop}, 32'd0);
        @(negedge clk);
        chk("add_push", {29'd0, StkPush, StkPop, StkTop}, 32'd4);
        chk("add_rv", {31'd0, ResultValid}, 32'd1);
        chk("add_result", {24'd0, Result}, 32'd8);
        chk("add_datain", {24'd0, StkDataIn}, 32'd8);
        @(negedge clk);
        chk("add_idle", {31'd0, TokReady}, 32'd1);
        op_result(3'd5, 8'd8, "peek_8");
        chk("peek_ptr", {27'd0, StkPtr, StkEmpty}, 32'd0);
        send(1'b1, 8'd6); wait_idle();
        chk("drop_empty", {31'd0, StkEmpty}, 32'd1);

        // Arithmetic wraparound and logic ops
        push(8'd3); push(8'd5);
        op_result(3'd1, 8'hFE, "sub_wrap");
        send(1'b1, 8'd6); wait_idle();
        push(8'hFF); push(8'h02);
        op_result(3'd0, 8'h01, "add_wrap");
        push(8'h3C);
        op_result(3'd4, 8'h3D, "xor");
        push(8'h0F);
        op_result(3'd2, 8'h0D, "and");
        push(8'h30);
        op_result(3'd3, 8'h3D, "or");
        send(1'b1, 8'd6); wait_idle();
        chk("ops_empty", {31'd0, StkEmpty}, 32'd1);

        // Underflow cases
        push(8'd1);
        op_error(3'd0, 1'b1, 2'd1, "add_one_entry");
        chk("underflow_ptr", {27'd0, StkPtr, StkEmpty}, 32'd0);
        send(1'b1, 8'd6); wait_idle();
        op_error(3'd5, 1'b1, 2'd1, "peek_empty");
        op_error(3'd6, 1'b1, 2'd1, "drop_empty");
        chk("underflow_still_empty", {31'd0, StkEmpty}, 32'd1);

        // Opcode 7
        push(8'd6); push(8'd7);
`ifdef RPN_EVALUATOR_MUL_EN
        op_result(3'd7, 8'd42, "mul");
        send(1'b1, 8'd6); wait_idle();
`else
        op_error(3'd7, 1'b1, 2'd3, "illegal_op7");
        chk("op7_entries", {27'd0, StkPtr, StkEmpty}, 32'd2);
        send(1'b1, 8'd6); wait_idle();
        send(1'b1, 8'd6); wait_idle();
`endif
        chk("op7_cleanup", {31'd0, StkEmpty}, 32'd1);

        // Overflow: fill 16, 17th push rejected
        for (int i = 0; i < 16; i++) push(8'(i + 16));
        chk("full_flag", {31'd0, StkFull}, 32'd1);
        op_error(3'd2, 1'b0, 2'd2, "overflow");
        op_result(3'd5, 8'h1F, "peek_after_overflow");

        // Reset during POP2 of an ADD
        send(1'b1, 8'd0);
        @(negedge clk);
        chk("pop2_reached", {31'd0, StkPop}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_strobes", {28'd0, StkEnable, StkPush, StkPop, StkTop}, 32'd0);
        chk("rst_mid_idle", {30'd0, TokReady, StkEmpty}, 32'd3);
        rst = 1'b0;
        push(8'd9);
        op_result(3'd5, 8'd9, "peek_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
